// File: rtl/issue_ctrl.sv
// Issue stage: 2-entry hold queue, RAW scoreboard, operand formation and
// local resolution of branches/jumps with a redirect pulse back to fetch.
module issue_ctrl #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [2:0]      fun3,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [6:0]      fun7,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] opc,
  output logic            is_busy,
  output logic            get_npc,
  output logic [XLEN-1:0] npc,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [6:0]      ex_opcode,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_fun3,
  output logic [6:0]      ex_fun7,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_sdata,
  output logic [XLEN-1:0] ex_pc,
  output logic            ovf
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [1:0] QFULL      = 2'(QDEPTH);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      fun3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      fun7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] opc;
  } instr_t;

  function automatic logic is_ct(input logic [6:0] op);
    return (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
  endfunction

  instr_t          in_i;
  instr_t          head;
  instr_t          q_q [QDEPTH];
  instr_t          q_d [QDEPTH];
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     sb_q, sb_d;
  logic            ovf_q, ovf_d;
  logic            get_npc_q, get_npc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic            ex_valid_q, ex_valid_d;
  logic [6:0]      ex_opcode_q, ex_opcode_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic [2:0]      ex_fun3_q, ex_fun3_d;
  logic [6:0]      ex_fun7_q, ex_fun7_d;
  logic [XLEN-1:0] ex_op1_q, ex_op1_d;
  logic [XLEN-1:0] ex_op2_q, ex_op2_d;
  logic [XLEN-1:0] ex_sdata_q, ex_sdata_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;

  logic            in_v, head_v, from_q, use1, use2, hazard;
  logic            head_br, issue, push, ct_in_q, taken;
  logic [XLEN-1:0] op1, op2;

  assign in_i = '{opcode: opcode, rd: rd, fun3: fun3, rs1: rs1, rs2: rs2,
                  fun7: fun7, imm: imm, opc: opc};

  always_comb begin
    in_v    = (opcode != 7'd0);
    from_q  = (cnt_q != 2'd0);
    head    = from_q ? q_q[0] : in_i;
    head_v  = from_q || in_v;
    head_br = (head.opcode == OPC_BRANCH);
    use1    = !((head.opcode == OPC_LUI) || (head.opcode == OPC_AUIPC) ||
                (head.opcode == OPC_JAL));
    use2    = (head.opcode == OPC_OP) || head_br || (head.opcode == OPC_STORE);
    hazard  = (use1 && (head.rs1 != 5'd0) && sb_q[head.rs1]) ||
              (use2 && (head.rs2 != 5'd0) && sb_q[head.rs2]);
    // Branches resolve here, so a stalled execute port does not block them.
    issue   = head_v && !hazard && (head_br || !ex_valid_q || ex_ready);
    push    = in_v && !(!from_q && issue);
    is_busy = from_q || (in_v && !issue);
    ct_in_q = (from_q && is_ct(q_q[0].opcode)) ||
              ((cnt_q == QFULL) && is_ct(q_q[1].opcode));

    case (head.fun3)
      3'b000:  taken = (rf_rdata1 == rf_rdata2);
      3'b001:  taken = (rf_rdata1 != rf_rdata2);
      3'b100:  taken = ($signed(rf_rdata1) <  $signed(rf_rdata2));
      3'b101:  taken = ($signed(rf_rdata1) >= $signed(rf_rdata2));
      3'b110:  taken = (rf_rdata1 <  rf_rdata2);
      3'b111:  taken = (rf_rdata1 >= rf_rdata2);
      default: taken = 1'b0;
    endcase

    case (head.opcode)
      OPC_AUIPC, OPC_JAL, OPC_JALR: op1 = head.opc;
      OPC_LUI:                      op1 = '0;
      default:                      op1 = rf_rdata1;
    endcase

    case (head.opcode)
      OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC: op2 = head.imm;
      OPC_JAL, OPC_JALR:                                  op2 = XLEN'(4);
      default:                                            op2 = rf_rdata2;
    endcase
  end

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (issue && from_q) begin
      q_d[0] = q_q[1];
      cnt_d  = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_q == QFULL) begin
        ovf_d = 1'b1;
      end else begin
        q_d[cnt_d[0]] = in_i;
        cnt_d         = cnt_d + 2'd1;
      end
    end
    // Fetch must be stalled while a control transfer waits for its redirect.
    if (in_v && ct_in_q) ovf_d = 1'b1;

    sb_d = sb_q;
    if (wb_en && (wb_rd != 5'd0)) sb_d[wb_rd] = 1'b0;
    if (issue && (head.rd != 5'd0) && !head_br && (head.opcode != OPC_STORE))
      sb_d[head.rd] = 1'b1;

    get_npc_d = 1'b0;
    npc_d     = npc_q;
    if (issue) begin
      case (head.opcode)
        OPC_BRANCH: begin
          get_npc_d = 1'b1;
          npc_d     = head.opc + (taken ? head.imm : XLEN'(4));
        end
        OPC_JAL: begin
          get_npc_d = 1'b1;
          npc_d     = head.opc + head.imm;
        end
        OPC_JALR: begin
          get_npc_d = 1'b1;
          npc_d     = (rf_rdata1 + head.imm) & ~XLEN'(1);
        end
        default: ;
      endcase
    end

    ex_valid_d  = ex_valid_q;
    ex_opcode_d = ex_opcode_q;
    ex_rd_d     = ex_rd_q;
    ex_fun3_d   = ex_fun3_q;
    ex_fun7_d   = ex_fun7_q;
    ex_op1_d    = ex_op1_q;
    ex_op2_d    = ex_op2_q;
    ex_sdata_d  = ex_sdata_q;
    ex_pc_d     = ex_pc_q;
    if (issue && !head_br) begin
      ex_valid_d  = 1'b1;
      ex_opcode_d = head.opcode;
      ex_rd_d     = head.rd;
      ex_fun3_d   = head.fun3;
      ex_fun7_d   = head.fun7;
      ex_op1_d    = op1;
      ex_op2_d    = op2;
      ex_sdata_d  = rf_rdata2;
      ex_pc_d     = head.opc;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) q_q[i] <= '0;
      cnt_q       <= 2'd0;
      sb_q        <= '0;
      ovf_q       <= 1'b0;
      get_npc_q   <= 1'b0;
      npc_q       <= '0;
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= '0;
      ex_rd_q     <= '0;
      ex_fun3_q   <= '0;
      ex_fun7_q   <= '0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_sdata_q  <= '0;
      ex_pc_q     <= '0;
    end else begin
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      sb_q        <= sb_d;
      ovf_q       <= ovf_d;
      get_npc_q   <= get_npc_d;
      npc_q       <= npc_d;
      ex_valid_q  <= ex_valid_d;
      ex_opcode_q <= ex_opcode_d;
      ex_rd_q     <= ex_rd_d;
      ex_fun3_q   <= ex_fun3_d;
      ex_fun7_q   <= ex_fun7_d;
      ex_op1_q    <= ex_op1_d;
      ex_op2_q    <= ex_op2_d;
      ex_sdata_q  <= ex_sdata_d;
      ex_pc_q     <= ex_pc_d;
    end
  end

  assign rf_raddr1 = head.rs1;
  assign rf_raddr2 = head.rs2;
  assign get_npc   = get_npc_q;
  assign npc       = npc_q;
  assign ovf       = ovf_q;
  assign ex_valid  = ex_valid_q;
  assign ex_opcode = ex_opcode_q;
  assign ex_rd     = ex_rd_q;
  assign ex_fun3   = ex_fun3_q;
  assign ex_fun7   = ex_fun7_q;
  assign ex_op1    = ex_op1_q;
  assign ex_op2    = ex_op2_q;
  assign ex_sdata  = ex_sdata_q;
  assign ex_pc     = ex_pc_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus a randomized stream checked
// against a queue/array reference model of the issue rules.
module tb_issue_ctrl;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LOAD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, OPI = 7'b0010011, OP = 7'b0110011;

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  fun3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  fun7;
    logic [31:0] imm;
    logic [31:0] opc;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ins_t        cur;
  logic        is_busy, get_npc, wb_en, ex_valid, ex_ready, ovf;
  logic [31:0] npc, rf_rdata1, rf_rdata2, ex_op1, ex_op2, ex_sdata, ex_pc;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, ex_rd;
  logic [6:0]  ex_opcode, ex_fun7;
  logic [2:0]  ex_fun3;
  logic [31:0] rf [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  issue_ctrl dut (
    .clk(clk), .rst(rst), .opcode(cur.opcode), .rd(cur.rd), .fun3(cur.fun3),
    .rs1(cur.rs1), .rs2(cur.rs2), .fun7(cur.fun7), .imm(cur.imm), .opc(cur.opc),
    .is_busy(is_busy), .get_npc(get_npc), .npc(npc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_en(wb_en), .wb_rd(wb_rd), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_fun3(ex_fun3), .ex_fun7(ex_fun7),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_sdata(ex_sdata), .ex_pc(ex_pc),
    .ovf(ovf)
  );

  // ---------------- reference model ----------------
  ins_t        mq[$];
  ins_t        h;
  logic [31:0] msb;
  bit          m_issue, m_busy, m_exv, m_getnpc, movf;
  logic [31:0] m_npc, m_op1, m_op2, m_sd, m_pc;
  logic [6:0]  m_exop, m_exf7;
  logic [4:0]  m_exrd;
  logic [2:0]  m_exf3;

  function automatic ins_t mk(logic [6:0] op, logic [4:0] d, logic [2:0] f3,
                              logic [4:0] s1, logic [4:0] s2, logic [31:0] im,
                              logic [31:0] pc);
    ins_t r;
    r.opcode = op; r.rd = d; r.fun3 = f3; r.rs1 = s1; r.rs2 = s2;
    r.fun7 = 7'h20; r.imm = im; r.opc = pc;
    return r;
  endfunction

  function automatic bit is_ct(logic [6:0] op);
    return op == BR || op == JAL || op == JALR;
  endfunction

  function automatic bit br_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_eval();
    bit hv, need1, need2, haz;
    if (mq.size() > 0) h = mq[0];
    else h = cur;
    hv = (mq.size() > 0) || (cur.opcode != 7'd0);
    need1 = !(h.opcode inside {LUI, AUIPC, JAL});
    need2 = h.opcode inside {OP, BR, ST};
    haz = (need1 && h.rs1 != 0 && msb[h.rs1]) || (need2 && h.rs2 != 0 && msb[h.rs2]);
    m_issue = hv && !haz && (h.opcode == BR || !m_exv || ex_ready);
    m_busy = (mq.size() > 0) || (cur.opcode != 7'd0 && !m_issue);
  endtask

  task automatic model_commit();
    logic [31:0] a, b;
    int n;
    bit ct_q;
    if (rst) begin
      mq.delete(); msb = 0; m_exv = 0; m_getnpc = 0; movf = 0; m_npc = 0;
      m_exop = 0; m_exrd = 0; m_exf3 = 0; m_exf7 = 0;
      m_op1 = 0; m_op2 = 0; m_sd = 0; m_pc = 0;
      return;
    end
    a = rf[h.rs1];
    b = rf[h.rs2];
    n = mq.size();
    ct_q = 0;
    foreach (mq[i]) if (is_ct(mq[i].opcode)) ct_q = 1;
    m_getnpc = 0;
    if (m_issue && h.opcode == BR) begin
      m_getnpc = 1; m_npc = br_taken(h.fun3, a, b) ? h.opc + h.imm : h.opc + 4;
    end else if (m_issue && h.opcode == JAL) begin
      m_getnpc = 1; m_npc = h.opc + h.imm;
    end else if (m_issue && h.opcode == JALR) begin
      m_getnpc = 1; m_npc = (a + h.imm) & ~32'd1;
    end
    if (m_issue && h.opcode != BR) begin
      m_exv = 1; m_exop = h.opcode; m_exrd = h.rd; m_exf3 = h.fun3; m_exf7 = h.fun7;
      m_pc = h.opc; m_sd = b;
      if (h.opcode inside {AUIPC, JAL, JALR}) m_op1 = h.opc;
      else if (h.opcode == LUI) m_op1 = 0;
      else m_op1 = a;
      if (h.opcode inside {OPI, LOAD, ST, LUI, AUIPC}) m_op2 = h.imm;
      else if (h.opcode inside {JAL, JALR}) m_op2 = 4;
      else m_op2 = b;
    end else if (ex_ready) begin
      m_exv = 0;
    end
    if (wb_en && wb_rd != 0) msb[wb_rd] = 0;
    if (m_issue && h.rd != 0 && h.opcode != BR && h.opcode != ST) msb[h.rd] = 1;
    if (m_issue && n > 0) void'(mq.pop_front());
    if (cur.opcode != 0) begin
      if (ct_q) movf = 1;
      if (!(n == 0 && m_issue)) begin
        if (n == 2) movf = 1;
        else mq.push_back(cur);
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; cur = mk(0, 0, 0, 0, 0, 0, 0); wb_en = 0; wb_rd = 0; ex_ready = 1;
    tick();
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (is_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", is_busy); end
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_exv: got %b want 0", ex_valid); end
    n_cmp++; if (get_npc !== 1'b0) begin n_err++; $display("FAIL rst_getnpc: got %b want 0", get_npc); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    n_cmp++; if ({npc, ex_op1, ex_op2, ex_pc, ex_sdata} !== 160'd0) begin
      n_err++; $display("FAIL rst_data: got %h %h %h %h %h want 0", npc, ex_op1, ex_op2, ex_pc, ex_sdata);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cur = mk(OPI, 1, 0, 0, 0, 32'h5, 32'h100);
    #1;
    n_cmp++; if (is_busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy0: got %b want 0", is_busy); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || ex_op2 !== 32'h5 || ex_op1 !== 32'h0) begin
      n_err++; $display("FAIL b2b_first: got v=%b rd=%0d op1=%h op2=%h want 1 1 0 5", ex_valid, ex_rd, ex_op1, ex_op2);
    end
    @(negedge clk);
    cur = mk(OPI, 2, 0, 0, 0, 32'h7, 32'h104);
    #1;
    n_cmp++; if (is_busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy1: got %b want 0", is_busy); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd2 || ex_op2 !== 32'h7 || ex_pc !== 32'h104) begin
      n_err++; $display("FAIL b2b_second: got v=%b rd=%0d op2=%h pc=%h want 1 2 7 104", ex_valid, ex_rd, ex_op2, ex_pc);
    end
    @(negedge clk);
    cur = mk(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", ex_valid); end
  endtask

  task automatic test_raw_hazard();
    do_reset();
    rf[1] = 32'h11;
    cur = mk(OPI, 1, 0, 0, 0, 32'h5, 32'h200);
    tick();
    @(negedge clk);
    cur = mk(OP, 3, 0, 1, 1, 0, 32'h204);
    #1;
    n_cmp++; if (is_busy !== 1'b1) begin n_err++; $display("FAIL raw_busy_arrive: got %b want 1", is_busy); end
    tick();
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      cur = mk(0, 0, 0, 0, 0, 0, 0);
      wb_en = (c == 4); wb_rd = 5'd1;
      #1;
      n_cmp++; if (is_busy !== 1'b1) begin n_err++; $display("FAIL raw_busy_c%0d: got %b want 1", c, is_busy); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL raw_held_c%0d: got %b want 0", c, ex_valid); end
    end
    @(negedge clk);
    wb_en = 0;
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_op1 !== 32'h11 || ex_op2 !== 32'h11) begin
      n_err++; $display("FAIL raw_issue: got v=%b rd=%0d op1=%h op2=%h want 1 3 11 11", ex_valid, ex_rd, ex_op1, ex_op2);
    end
    @(negedge clk);
    cur = mk(OPI, 4, 0, 3, 0, 1, 32'h208);
    #1;
    n_cmp++; if (is_busy !== 1'b1) begin n_err++; $display("FAIL raw_sb3: got busy %b want 1", is_busy); end
    tick();
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      rf[5] = 32'd7; rf[6] = (k == 0) ? 32'd7 : 32'd8;
      cur = mk(BR, 5'h10, 3'd0, 5, 6, 32'h10, 32'h40);
      tick();
      n_cmp++; if (get_npc !== 1'b1 || npc !== ((k == 0) ? 32'h50 : 32'h44) || ex_valid !== 1'b0) begin
        n_err++; $display("FAIL br_redirect%0d: got g=%b npc=%h v=%b want 1 %h 0", k, get_npc, npc, ex_valid, (k == 0) ? 32'h50 : 32'h44);
      end
      @(negedge clk);
      cur = mk(0, 0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (get_npc !== 1'b0 || ex_valid !== 1'b0) begin
        n_err++; $display("FAIL br_pulse%0d: got g=%b v=%b want 0 0", k, get_npc, ex_valid);
      end
    end
  endtask

  task automatic test_jalr();
    do_reset();
    rf[7] = 32'h103;
    cur = mk(JALR, 1, 0, 7, 0, 32'h2, 32'h200);
    tick();
    n_cmp++; if (get_npc !== 1'b1 || npc !== 32'h104) begin
      n_err++; $display("FAIL jalr_npc: got g=%b npc=%h want 1 104", get_npc, npc);
    end
    n_cmp++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h200 || ex_op2 !== 32'd4 || ex_rd !== 5'd1) begin
      n_err++; $display("FAIL jalr_ex: got v=%b op1=%h op2=%h rd=%0d want 1 200 4 1", ex_valid, ex_op1, ex_op2, ex_rd);
    end
    @(negedge clk);
    cur = mk(OPI, 2, 0, 1, 0, 0, 32'h104);
    #1;
    n_cmp++; if (is_busy !== 1'b1) begin n_err++; $display("FAIL jalr_sb1: got busy %b want 1", is_busy); end
    tick();
    n_cmp++; if (get_npc !== 1'b0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL jalr_after: got g=%b ovf=%b want 0 0", get_npc, ovf);
    end
  endtask

  task automatic test_stall_ovf();
    do_reset();
    ex_ready = 0;
    cur = mk(OPI, 1, 0, 0, 0, 32'h11, 32'h300);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) cur = mk(OPI, 5'(2 + i), 0, 0, 0, 32'h20 + i, 32'h304 + 4 * i);
      else cur = mk(0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (is_busy !== 1'b1) begin n_err++; $display("FAIL stall_busy%0d: got %b want 1", i, is_busy); end
      tick();
      n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || ex_op2 !== 32'h11 || ex_pc !== 32'h300) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b rd=%0d op2=%h pc=%h want 1 1 11 300", i, ex_valid, ex_rd, ex_op2, ex_pc);
      end
      n_cmp++; if (ovf !== (i >= 2)) begin n_err++; $display("FAIL stall_ovf%0d: got %b want %b", i, ovf, i >= 2); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1;
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ovf !== 1'b0 || get_npc !== 1'b0) begin
      n_err++; $display("FAIL rstmid_regs: got v=%b ovf=%b g=%b want 0 0 0", ex_valid, ovf, get_npc);
    end
    @(negedge clk);
    rst = 0;
    #1;
    n_cmp++; if (is_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", is_busy); end
    ex_ready = 1;
    cur = mk(OP, 5, 0, 1, 2, 0, 32'h400);
    #1;
    n_cmp++; if (is_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_sb: got busy %b want 0", is_busy); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin
      n_err++; $display("FAIL rstmid_issue: got v=%b rd=%0d want 1 5", ex_valid, ex_rd);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [9] = '{LUI, AUIPC, JAL, JALR, BR, LOAD, ST, OPI, OP};
    logic [31:0] vals [5] = '{32'd0, 32'd1, 32'd7, 32'hffffffff, 32'h80000000};
    bit ct_wait, prev_busy;
    ins_t r;
    do_reset();
    for (int i = 1; i < 32; i++)
      rf[i] = ($urandom_range(0, 5) == 5) ? $urandom : vals[$urandom_range(0, 4)];
    ct_wait = 0; prev_busy = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (m_getnpc) ct_wait = 0;
      ex_ready = ($urandom_range(0, 3) != 0);
      wb_en = ($urandom_range(0, 2) == 0);
      wb_rd = 5'($urandom_range(0, 7));
      if (!prev_busy && !ct_wait && $urandom_range(0, 2) != 0) begin
        r = mk(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64)),
               $urandom & ~32'd3);
        r.fun7 = 7'($urandom_range(0, 127));
        if (is_ct(r.opcode)) ct_wait = 1;
        cur = r;
      end else begin
        cur = mk(0, 0, 0, 0, 0, 0, 0);
      end
      #1;
      model_eval();
      prev_busy = m_busy;
      n_cmp++; if (is_busy !== m_busy) begin n_err++; $display("FAIL rnd_busy@%0d: got %b want %b", n, is_busy, m_busy); end
      n_cmp++; if (rf_raddr1 !== h.rs1 || rf_raddr2 !== h.rs2) begin
        n_err++; $display("FAIL rnd_raddr@%0d: got %0d %0d want %0d %0d", n, rf_raddr1, rf_raddr2, h.rs1, h.rs2);
      end
      tick();
      n_cmp++; if (ex_valid !== m_exv || get_npc !== m_getnpc || ovf !== movf) begin
        n_err++; $display("FAIL rnd_ctl@%0d: got v=%b g=%b ovf=%b want %b %b %b", n, ex_valid, get_npc, ovf, m_exv, m_getnpc, movf);
      end
      if (m_getnpc) begin
        n_cmp++; if (npc !== m_npc) begin n_err++; $display("FAIL rnd_npc@%0d: got %h want %h", n, npc, m_npc); end
      end
      if (m_exv) begin
        n_cmp++;
        if (ex_opcode !== m_exop || ex_rd !== m_exrd || ex_fun3 !== m_exf3 || ex_fun7 !== m_exf7 ||
            ex_op1 !== m_op1 || ex_op2 !== m_op2 || ex_sdata !== m_sd || ex_pc !== m_pc) begin
          n_err++;
          $display("FAIL rnd_ex@%0d: got %h %0d %0d %h %h %h %h %h want %h %0d %0d %h %h %h %h %h", n,
                   ex_opcode, ex_rd, ex_fun3, ex_fun7, ex_op1, ex_op2, ex_sdata, ex_pc,
                   m_exop, m_exrd, m_exf3, m_exf7, m_op1, m_op2, m_sd, m_pc);
        end
      end
    end
  endtask

  initial begin
    cur = mk(0, 0, 0, 0, 0, 0, 0);
    wb_en = 0; wb_rd = 0; ex_ready = 1;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
    rf[0] = 0;
    mq.delete(); msb = 0; m_exv = 0; m_getnpc = 0; movf = 0;
    test_reset();
    test_back_to_back();
    test_raw_hazard();
    test_branch();
    test_jalr();
    test_stall_ovf();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
